// File: rtl/rv32_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle control unit: opcodes, state
// codes, datapath select encodings and the packed control vector.
package rv32_ctrl_pkg;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // FSM state codes
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  // Datapath select encodings
  localparam logic [1:0] ALU_SRC_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd2;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MDR = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'd2;

  // Everything the decoder drives in one cycle
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       halted;
  } ctrl_t;

  // ECALL is the SYSTEM opcode with funct3 == 0; CSR forms are not handled.
  function automatic logic is_ecall(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_ECALL) && (f3 == 3'b000);
  endfunction

  // Opcodes that proceed from ID into EX; anything else is retired as a NOP.
  function automatic logic needs_ex(input logic [6:0] op);
    return (op == OP_R)      || (op == OP_I_ALU) || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR)   || (op == OP_LUI)   || (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Shared memory-port handshake: the control unit requests, memory answers
// with mem_ready in the cycle the access completes.
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, mem_read, mem_write, i_or_d, input mem_ready);
  modport slave  (input mem_req, mem_read, mem_write, i_or_d, output mem_ready);
endinterface

// File: rtl/ctrl_output_decode.sv
// Combinational state + opcode -> control vector. Moore outputs, except the
// IF fetch strobes (gated by mem_ready) and the taken-branch PC update.
module ctrl_output_decode
  import rv32_ctrl_pkg::*;
(
  input  logic       active,     // low while reset is asserted: all outputs forced off
  input  logic [2:0] state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_bcond,
  output ctrl_t      ctrl
);

  // Control vector for the current state
  always_comb begin
    // NOTE: every field defaults to 0 first, so no path leaves ctrl unassigned (no latch).
    ctrl = '0;
    if (active) begin
      case (state)
        S_IF: begin
          ctrl.mem_req   = 1'b1;
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = ALU_SRC_B_FOUR;        // PC + 4
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;             // pc_source stays 0: ALU result
        end
        S_ID: begin
          ctrl.alu_src_b = ALU_SRC_B_IMM;         // PC + imm -> ALUOut as jump/branch target
        end
        S_EX: begin
          case (opcode)
            OP_R: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = ALU_SRC_B_RS2;
              ctrl.alu_op    = ALU_OP_FUNCT;
            end
            OP_I_ALU: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = ALU_SRC_B_IMM;
              ctrl.alu_op    = ALU_OP_FUNCT;
            end
            // LUI: the rs1 port reads x0, so rs1 + imm is the upper immediate.
            OP_LOAD, OP_STORE, OP_LUI: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = ALU_SRC_B_IMM;
            end
            OP_AUIPC: begin
              ctrl.alu_src_b = ALU_SRC_B_IMM;
            end
            OP_BRANCH: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = ALU_SRC_B_RS2;
              ctrl.alu_op    = ALU_OP_BRANCH;
              ctrl.pc_write  = alu_bcond;
              ctrl.pc_source = alu_bcond;         // target already sits in ALUOut
            end
            OP_JAL: begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = 1'b1;
            end
            OP_JALR: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = ALU_SRC_B_IMM;
              ctrl.pc_write  = 1'b1;              // rs1 + imm straight from the ALU
            end
            default: ;
          endcase
        end
        S_MEM: begin
          ctrl.mem_req   = 1'b1;
          ctrl.i_or_d    = 1'b1;
          ctrl.mem_read  = (opcode == OP_LOAD);
          ctrl.mem_write = (opcode == OP_STORE);
        end
        S_WB: begin
          ctrl.reg_write = 1'b1;
          if (opcode == OP_LOAD)
            ctrl.mem_to_reg = MEM_TO_REG_MDR;
          else if ((opcode == OP_JAL) || (opcode == OP_JALR))
            ctrl.mem_to_reg = MEM_TO_REG_PC4;
          else
            ctrl.mem_to_reg = MEM_TO_REG_ALU;
        end
        S_HALT: begin
          ctrl.halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// RV32I multi-cycle control FSM: state register, memory wait counter with
// timeout, sticky error flag. Output decoding lives in ctrl_output_decode.
module multicycle_control_unit
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,   // 0 disables the timeout
  parameter logic [2:0]  RESET_STATE = S_IF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [6:0]                        opcode,
  input  logic [2:0]                        funct3,
  input  logic                              is_halt_cond,
  input  logic                              alu_bcond,
  multicycle_control_unit_if.master         mem,
  output logic                              ir_write,
  output logic                              pc_write,
  output logic                              pc_source,
  output logic                              alu_src_a,
  output logic [1:0]                        alu_src_b,
  output logic [1:0]                        alu_op,
  output logic                              reg_write,
  output logic [1:0]                        mem_to_reg,
  output logic                              halted,
  output logic                              mem_err
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             timeout;
  ctrl_t            ctrl;

  ctrl_output_decode u_decode (
    .active    (reset_n),
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem.mem_ready),
    .alu_bcond (alu_bcond),
    .ctrl      (ctrl)
  );

  // A ready arriving on the last allowed cycle wins: waiting is already false.
  assign waiting = ctrl.mem_req && !mem.mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting &&
                   (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Instruction sequencing; a memory timeout overrides everything
  always_comb begin
    state_next = state;
    case (state)
      S_IF:  if (mem.mem_ready) state_next = S_ID;
      S_ID: begin
        if (is_ecall(opcode, funct3))
          state_next = is_halt_cond ? S_HALT : S_IF;
        else if (needs_ex(opcode))
          state_next = S_EX;
        else
          state_next = S_IF;
      end
      S_EX: begin
        case (opcode)
          OP_LOAD, OP_STORE:                 state_next = S_MEM;
          OP_R, OP_I_ALU, OP_LUI, OP_AUIPC,
          OP_JAL, OP_JALR:                   state_next = S_WB;
          default:                           state_next = S_IF;   // branch
        endcase
      end
      S_MEM: if (mem.mem_ready) state_next = (opcode == OP_LOAD) ? S_WB : S_IF;
      S_WB:   state_next = S_IF;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IF;
    endcase
    if (timeout) state_next = S_HALT;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_next;
  end

  // Wait counter: counts stalled memory cycles, clears on ready or state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if ((MEM_TIMEOUT != 0) && waiting && (state_next == state))
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end

  // Sticky memory-timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     mem_err <= 1'b0;
    else if (timeout) mem_err <= 1'b1;
  end

  assign mem.mem_req   = ctrl.mem_req;
  assign mem.mem_read  = ctrl.mem_read;
  assign mem.mem_write = ctrl.mem_write;
  assign mem.i_or_d    = ctrl.i_or_d;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign halted        = ctrl.halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus
// random instruction streams, checked cycle by cycle against an
// instruction-level model of the expected control outputs.
module tb_multicycle_control_unit;

  localparam int TIMEOUT = 4;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       halted;
    logic       mem_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_halt_cond;
  logic       alu_bcond;
  logic       ir_write, pc_write, pc_source, alu_src_a, reg_write, halted, mem_err;
  logic [1:0] alu_src_b, alu_op, mem_to_reg;

  multicycle_control_unit_if mem_bus ();

  multicycle_control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .is_halt_cond (is_halt_cond),
    .alu_bcond    (alu_bcond),
    .mem          (mem_bus),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_source    (pc_source),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .halted       (halted),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [6:0] op_tab [13] = '{OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
                              OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, 7'b0001111,
                              7'b1111111, 7'b0000000};

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t observed();
    vec_t v;
    v = '{mem_bus.mem_req, mem_bus.mem_read, mem_bus.mem_write, mem_bus.i_or_d,
          ir_write, pc_write, pc_source, alu_src_a, alu_src_b, alu_op,
          reg_write, mem_to_reg, halted, mem_err};
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit known(input logic [6:0] op);
    return op inside {OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
  endfunction

  // ---------- reference model: expected outputs per instruction phase ----------
  function automatic vec_t v_fetch(input logic rdy);
    vec_t v = '0;
    v.mem_req = 1; v.mem_read = 1; v.alu_src_b = 2'd1;
    v.ir_write = rdy; v.pc_write = rdy;
    return v;
  endfunction

  function automatic vec_t v_decode();
    vec_t v = '0;
    v.alu_src_b = 2'd2;
    return v;
  endfunction

  function automatic vec_t v_exec(input logic [6:0] op, input logic bc);
    vec_t v = '0;
    if (op == OPC_R)                            begin v.alu_src_a = 1; v.alu_op = 2'd2; end
    if (op == OPC_I)                            begin v.alu_src_a = 1; v.alu_src_b = 2'd2; v.alu_op = 2'd2; end
    if (op inside {OPC_LOAD, OPC_STORE, OPC_LUI}) begin v.alu_src_a = 1; v.alu_src_b = 2'd2; end
    if (op == OPC_AUIPC)                        v.alu_src_b = 2'd2;
    if (op == OPC_BRANCH)                       begin v.alu_src_a = 1; v.alu_op = 2'd1; v.pc_write = bc; v.pc_source = bc; end
    if (op == OPC_JAL)                          begin v.pc_write = 1; v.pc_source = 1; end
    if (op == OPC_JALR)                         begin v.alu_src_a = 1; v.alu_src_b = 2'd2; v.pc_write = 1; end
    return v;
  endfunction

  function automatic vec_t v_mem(input logic [6:0] op);
    vec_t v = '0;
    v.mem_req = 1; v.i_or_d = 1;
    v.mem_read = (op == OPC_LOAD); v.mem_write = (op == OPC_STORE);
    return v;
  endfunction

  function automatic vec_t v_wb(input logic [6:0] op);
    vec_t v = '0;
    v.reg_write = 1;
    v.mem_to_reg = (op == OPC_LOAD) ? 2'd1 : (op inside {OPC_JAL, OPC_JALR}) ? 2'd2 : 2'd0;
    return v;
  endfunction

  function automatic vec_t v_halt(input logic err);
    vec_t v = '0;
    v.halted = 1; v.mem_err = err;
    return v;
  endfunction

  // ---------- stimulus primitives (entered just after a falling edge) ----------
  task automatic cyc(input logic rdy, input logic [6:0] op, input logic [2:0] f3,
                     input logic bc, input logic hc, input vec_t exp, input string tag);
    mem_bus.mem_ready = rdy;
    opcode = op; funct3 = f3; alu_bcond = bc; is_halt_cond = hc;
    #1 check(tag, observed(), exp);
    @(negedge clk);
  endtask

  // One instruction; waits of TIMEOUT or more model a memory that never answers.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int w1,
                           input int w2, input logic bc, input logic hc,
                           output bit stopped, output bit tmo);
    stopped = 0; tmo = 0;
    for (int i = 0; i < w1 && i < TIMEOUT; i++)
      cyc(1'b0, 7'($urandom), 3'($urandom), rb(), rb(), v_fetch(1'b0), "if_wait");
    if (w1 >= TIMEOUT) begin stopped = 1; tmo = 1; return; end
    cyc(1'b1, 7'($urandom), 3'($urandom), rb(), rb(), v_fetch(1'b1), "if_ready");
    cyc(rb(), op, f3, rb(), hc, v_decode(), "id");
    if (op == OPC_SYSTEM && f3 == 3'd0) begin stopped = hc; return; end
    if (!known(op)) return;
    cyc(rb(), op, f3, bc, rb(), v_exec(op, bc), "ex");
    if (op == OPC_BRANCH) return;
    if (op inside {OPC_LOAD, OPC_STORE}) begin
      for (int i = 0; i < w2 && i < TIMEOUT; i++)
        cyc(1'b0, op, f3, rb(), rb(), v_mem(op), "mem_wait");
      if (w2 >= TIMEOUT) begin stopped = 1; tmo = 1; return; end
      cyc(1'b1, op, f3, rb(), rb(), v_mem(op), "mem_ready");
      if (op == OPC_STORE) return;
    end
    cyc(rb(), op, f3, rb(), rb(), v_wb(op), "wb");
  endtask

  task automatic halt_hold(input int n, input logic err, input string tag);
    for (int i = 0; i < n; i++)
      cyc(rb(), 7'($urandom), 3'($urandom), rb(), rb(), v_halt(err), tag);
  endtask

  // Reset pulse asserted between clock edges; outputs must drop immediately.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 check({tag, "_async"}, observed(), '0);
    @(negedge clk);
    mem_bus.mem_ready = 1'b1;
    #1 check({tag, "_held"}, observed(), '0);
    reset_n = 1'b1;
  endtask

  initial begin
    bit stp, tmo;
    int k, w1, w2;
    logic [6:0] op;
    logic [2:0] f3;

    reset_n = 1'b0; mem_bus.mem_ready = 1'b0;
    opcode = '0; funct3 = '0; alu_bcond = 1'b0; is_halt_cond = 1'b0;
    @(negedge clk);
    #1 check("reset_state", observed(), '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed scenarios
    run_instr(OPC_R, 3'd0, 0, 0, 1'b0, 1'b0, stp, tmo);         // IF,ID,EX,WB
    run_instr(OPC_LOAD, 3'd2, 3, 2, 1'b0, 1'b0, stp, tmo);      // delayed fetch and load
    run_instr(OPC_BRANCH, 3'd0, 0, 0, 1'b1, 1'b0, stp, tmo);    // taken
    run_instr(OPC_BRANCH, 3'd0, 1, 0, 1'b0, 1'b0, stp, tmo);    // not taken
    run_instr(OPC_JAL, 3'd0, 0, 0, 1'b0, 1'b0, stp, tmo);
    run_instr(OPC_JALR, 3'd0, 2, 0, 1'b0, 1'b0, stp, tmo);
    run_instr(OPC_STORE, 3'd2, 0, 3, 1'b0, 1'b0, stp, tmo);     // ready on last allowed cycle
    run_instr(7'b1111111, 3'd0, 0, 0, 1'b0, 1'b0, stp, tmo);    // unknown -> NOP
    run_instr(OPC_SYSTEM, 3'd1, 0, 0, 1'b0, 1'b1, stp, tmo);    // CSR form -> NOP
    run_instr(OPC_SYSTEM, 3'd0, 0, 0, 1'b0, 1'b0, stp, tmo);    // ECALL, no halt
    run_instr(OPC_AUIPC, 3'd0, 0, 0, 1'b0, 1'b0, stp, tmo);
    run_instr(OPC_SYSTEM, 3'd0, 0, 0, 1'b0, 1'b1, stp, tmo);    // ECALL, halt
    halt_hold(100, 1'b0, "halt_hold");
    do_reset("rst_after_halt");

    run_instr(OPC_R, 3'd0, TIMEOUT, 0, 1'b0, 1'b0, stp, tmo);   // fetch timeout
    halt_hold(3, 1'b1, "if_timeout");
    do_reset("rst_after_if_tmo");

    run_instr(OPC_STORE, 3'd2, 1, TIMEOUT, 1'b0, 1'b0, stp, tmo); // store timeout
    halt_hold(3, 1'b1, "mem_timeout");
    do_reset("rst_after_mem_tmo");

    // Reset in the middle of a load's memory access
    cyc(1'b1, 7'd0, 3'd0, 1'b0, 1'b0, v_fetch(1'b1), "mid_if");
    cyc(1'b0, OPC_LOAD, 3'd2, 1'b0, 1'b0, v_decode(), "mid_id");
    cyc(1'b0, OPC_LOAD, 3'd2, 1'b0, 1'b0, v_exec(OPC_LOAD, 1'b0), "mid_ex");
    cyc(1'b0, OPC_LOAD, 3'd2, 1'b0, 1'b0, v_mem(OPC_LOAD), "mid_mem");
    mem_bus.mem_ready = 1'b0;
    do_reset("rst_mid_mem");

    // Random instruction stream
    for (int n = 0; n < 250; n++) begin
      k  = $urandom_range(0, 12);
      op = op_tab[k];
      f3 = 3'($urandom);
      if (op == OPC_SYSTEM) f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      w1 = ($urandom_range(0, 15) == 0) ? TIMEOUT : $urandom_range(0, 3);
      w2 = ($urandom_range(0, 15) == 0) ? TIMEOUT : $urandom_range(0, 3);
      run_instr(op, f3, w1, w2, rb(), ($urandom_range(0, 2) == 0), stp, tmo);
      if (stp) begin
        halt_hold(4, tmo, "rand_halt");
        do_reset("rand_rst");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
